comparator: RTL and testbench

32-bit branch-condition comparator for the MIPS pipeline's decode stage. It evaluates one MIPS branch/set condition on two register operands (BEQ, BNE, BLTZ, BGEZ, BLEZ, BGTZ, SLT, SLTU) and registers a single-bit result plus raw relation flags. The hazard/PC-select logic consumes the result one cycle after the operands are presented.

---
 rtl/cmp_pkg.sv | 17 +
 rtl/cmp_core.sv | 47 ++++
 rtl/comparator.sv | 57 +++++
 tb/tb_comparator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the decode-stage branch/set condition comparator.
package cmp_pkg;

    localparam int CMP_WIDTH = 32;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NE   = 3'b001,
        CMP_LTZ  = 3'b010,
        CMP_GEZ  = 3'b011,
        CMP_LEZ  = 3'b100,
        CMP_GTZ  = 3'b101,
        CMP_SLT  = 3'b110,
        CMP_SLTU = 3'b111
    } cmp_op_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational relation and condition evaluation for one operand pair.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             eq,
    output logic             lt_s,
    output logic             lt_u,
    output logic             zero,
    output logic             result
);

    logic             borrow;
    logic [WIDTH-1:0] diff_unused;
    logic             sign_a;
    logic             sign_b;

    // The borrow out of the zero-extended subtraction is the unsigned less-than.
    assign {borrow, diff_unused} = {1'b0, a} - {1'b0, b};

    assign sign_a = a[WIDTH-1];
    assign sign_b = b[WIDTH-1];
    assign eq     = (a == b);
    assign lt_u   = borrow;
    assign lt_s   = (sign_a != sign_b) ? sign_a : borrow;
    assign zero   = ~(|a);

    always_comb begin
        result = 1'b0;
        unique case (cmp_op_t'(op))
            CMP_EQ:   result = eq;
            CMP_NE:   result = ~eq;
            CMP_LTZ:  result = sign_a;
            CMP_GEZ:  result = ~sign_a;
            CMP_LEZ:  result = sign_a | zero;
            CMP_GTZ:  result = ~sign_a & ~zero;
            CMP_SLT:  result = lt_s;
            CMP_SLTU: result = lt_u;
            default:  result = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparator.sv
// Branch-condition comparator: evaluates one condition per cycle and registers
// the result and relation flags with a single cycle of latency.
module comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       cmp_op,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             output_bit,
    output logic             out_valid,
    output logic             eq_flag,
    output logic             lt_s_flag,
    output logic             lt_u_flag
);

    logic core_eq;
    logic core_lt_s;
    logic core_lt_u;
    logic zero_unused;
    logic core_result;

    cmp_core #(.WIDTH(WIDTH)) core (
        .a      (A_in),
        .b      (B_in),
        .op     (cmp_op),
        .eq     (core_eq),
        .lt_s   (core_lt_s),
        .lt_u   (core_lt_u),
        .zero   (zero_unused),
        .result (core_result)
    );

    // Result and flags hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_bit <= 1'b0;
            out_valid  <= 1'b0;
            eq_flag    <= 1'b0;
            lt_s_flag  <= 1'b0;
            lt_u_flag  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                output_bit <= core_result;
                eq_flag    <= core_eq;
                lt_s_flag  <= core_lt_s;
                lt_u_flag  <= core_lt_u;
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed vector table plus hold/reset sequences.
module tb_comparator;
    import cmp_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_bit;
        logic        exp_eq;
        logic        exp_lts;
        logic        exp_ltu;
    } vec_t;

    localparam int NUM_VECS = 17;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  cmp_op;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        output_bit;
    logic        out_valid;
    logic        eq_flag;
    logic        lt_s_flag;
    logic        lt_u_flag;

    int   compared;
    int   mismatched;
    vec_t vecs [NUM_VECS];

    comparator #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cmp_op     (cmp_op),
        .A_in       (A_in),
        .B_in       (B_in),
        .output_bit (output_bit),
        .out_valid  (out_valid),
        .eq_flag    (eq_flag),
        .lt_s_flag  (lt_s_flag),
        .lt_u_flag  (lt_u_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic valid, input logic reset_in,
                                 input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        in_valid = valid;
        rst      = reset_in;
        cmp_op   = op;
        A_in     = a;
        B_in     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %b, expected %b", name, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic exp_bit, input logic exp_eq,
                               input logic exp_lts, input logic exp_ltu);
        checkField(name, "out_valid",  out_valid,  exp_valid);
        checkField(name, "output_bit", output_bit, exp_bit);
        checkField(name, "eq_flag",    eq_flag,    exp_eq);
        checkField(name, "lt_s_flag",  lt_s_flag,  exp_lts);
        checkField(name, "lt_u_flag",  lt_u_flag,  exp_ltu);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        cmp_op     = 3'b000;
        A_in       = 32'h0;
        B_in       = 32'h0;

        //             op        A             B             bit   eq    lts   ltu
        vecs[0]  = '{CMP_EQ,   32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{CMP_EQ,   32'h0000000A, 32'h0000000F, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{CMP_NE,   32'h0000000A, 32'h0000000F, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{CMP_EQ,   32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{CMP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{CMP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{CMP_LTZ,  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{CMP_GEZ,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{CMP_LEZ,  32'h00000000, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{CMP_GTZ,  32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{CMP_GEZ,  32'h00000000, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{CMP_LEZ,  32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{CMP_GTZ,  32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{CMP_GTZ,  32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{CMP_SLTU, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{CMP_SLT,  32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{CMP_NE,   32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        applyStimulus(1'b0, 1'b1, CMP_EQ, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, CMP_EQ, 32'h5, 32'h5);
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back table vectors, one per cycle
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].exp_bit,
                        vecs[i].exp_eq, vecs[i].exp_lts, vecs[i].exp_ltu);
        end

        // Idle cycles hold result and flags while out_valid drops
        applyStimulus(1'b1, 1'b0, CMP_SLTU, 32'h00000003, 32'h00000009);
        checkOutput("hold_setup", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, CMP_EQ, 32'h00000009, 32'h00000009);
        checkOutput("hold_idle1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, CMP_GEZ, 32'h80000000, 32'h00000001);
        checkOutput("hold_idle2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset wins over a simultaneous valid input
        applyStimulus(1'b1, 1'b0, CMP_EQ, 32'h00000005, 32'h00000005);
        checkOutput("pre_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, CMP_EQ, 32'h00000005, 32'h00000005);
        checkOutput("reset_with_valid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, CMP_EQ, 32'h00000005, 32'h00000005);
        checkOutput("release_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First accepted input after reset appears one edge later
        applyStimulus(1'b1, 1'b0, CMP_LTZ, 32'h80000000, 32'h00000001);
        checkOutput("first_after_reset", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
